// File: rtl/seg7_scan_driver.sv
// seg7_scan_driver
// Time-multiplexed seven-segment driver. It latches a packed hex value plus
// decimal points into a shadow register and scans one digit per prescaler
// period. New data is moved into the display register only at frame
// boundaries, so a frame never mixes old and new digits. The first cycle of
// every slot is a dead-time cycle with all anodes off, which suppresses
// ghosting. All pin outputs are registered.

module seg7_scan_driver #(
  parameter int   DIGITS    = 4,
  parameter int   PRESCALE  = 50000,
  parameter logic INVERT    = 1'b1,
  parameter logic AN_INVERT = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   value,
  input  logic [DIGITS-1:0]     dp,
  input  logic                  blank_lz,
  output logic [6:0]            seg,
  output logic                  dp_out,
  output logic [DIGITS-1:0]     an,
  output logic                  frame
);

  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [PW-1:0] PCNT_LAST = PW'(PRESCALE - 1);
  localparam logic [IW-1:0] IDX_LAST  = IW'(DIGITS - 1);

  // Active-high gfedcba segment pattern for one hex nibble.
  function automatic logic [6:0] hex_pattern(input logic [3:0] nib);
    logic [6:0] pat;
    case (nib)
      4'h0:    pat = 7'h3F;
      4'h1:    pat = 7'h06;
      4'h2:    pat = 7'h5B;
      4'h3:    pat = 7'h4F;
      4'h4:    pat = 7'h66;
      4'h5:    pat = 7'h6D;
      4'h6:    pat = 7'h7D;
      4'h7:    pat = 7'h07;
      4'h8:    pat = 7'h7F;
      4'h9:    pat = 7'h6F;
      4'hA:    pat = 7'h77;
      4'hB:    pat = 7'h7C;
      4'hC:    pat = 7'h39;
      4'hD:    pat = 7'h5E;
      4'hE:    pat = 7'h79;
      4'hF:    pat = 7'h71;
      default: pat = 7'h00;
    endcase
    return pat;
  endfunction

  logic [PW-1:0]       pcnt_r;
  logic [IW-1:0]       idx_r;
  logic [4*DIGITS-1:0] shadow_value_r;
  logic [DIGITS-1:0]   shadow_dp_r;
  logic [4*DIGITS-1:0] disp_value_r;
  logic [DIGITS-1:0]   disp_dp_r;
  logic                frame_r;
  logic [6:0]          seg_r;
  logic                dp_out_r;
  logic [DIGITS-1:0]   an_r;

  logic                tick_s;
  logic                boundary_s;
  logic                zero_run_s;
  logic [DIGITS-1:0]   blank_s;
  logic [3:0]          nib_s;
  logic                digit_dp_s;
  logic                digit_blank_s;
  logic [DIGITS-1:0]   onehot_s;
  logic [6:0]          pattern_s;

  assign tick_s     = (pcnt_r == PCNT_LAST);
  assign boundary_s = tick_s && (idx_r == IDX_LAST);

  // Prescaler and digit index: one slot per PRESCALE cycles, digits wrap.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pcnt_r <= {PW{1'b0}};
      idx_r  <= {IW{1'b0}};
    end else if (tick_s) begin
      pcnt_r <= {PW{1'b0}};
      if (idx_r == IDX_LAST) begin
        idx_r <= {IW{1'b0}};
      end else begin
        idx_r <= idx_r + IW'(1);
      end
    end else begin
      pcnt_r <= pcnt_r + PW'(1);
      idx_r  <= idx_r;
    end
  end

  // Shadow captures every load; the display copy moves only at frame
  // boundaries, taking a same-cycle load directly so it costs no extra frame.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shadow_value_r <= {(4*DIGITS){1'b0}};
      shadow_dp_r    <= {DIGITS{1'b0}};
      disp_value_r   <= {(4*DIGITS){1'b0}};
      disp_dp_r      <= {DIGITS{1'b0}};
      frame_r        <= 1'b0;
    end else begin
      if (load) begin
        shadow_value_r <= value;
        shadow_dp_r    <= dp;
      end
      if (boundary_s) begin
        disp_value_r <= load ? value : shadow_value_r;
        disp_dp_r    <= load ? dp    : shadow_dp_r;
      end
      frame_r <= boundary_s;
    end
  end

  // Leading-zero map: scan from the top digit down while every nibble is 0.
  always_comb begin
    zero_run_s = 1'b1;
    blank_s    = {DIGITS{1'b0}};
    for (int i = DIGITS - 1; i >= 0; i--) begin
      zero_run_s = zero_run_s & (disp_value_r[4*i +: 4] == 4'h0);
      if (i == 0) begin
        blank_s[i] = 1'b0;
      end else begin
        blank_s[i] = blank_lz & zero_run_s;
      end
    end
  end

  // Select the nibble, dp, blank flag and anode bit of the current digit.
  always_comb begin
    nib_s         = 4'h0;
    digit_dp_s    = 1'b0;
    digit_blank_s = 1'b0;
    onehot_s      = {DIGITS{1'b0}};
    for (int i = 0; i < DIGITS; i++) begin
      if (idx_r == IW'(i)) begin
        nib_s         = disp_value_r[4*i +: 4];
        digit_dp_s    = disp_dp_r[i];
        digit_blank_s = blank_s[i];
        onehot_s[i]   = 1'b1;
      end else begin
        onehot_s[i]   = 1'b0;
      end
    end
    pattern_s = digit_blank_s ? 7'h00 : hex_pattern(nib_s);
  end

  // Pin registers; anodes are forced off on the first (dead) cycle of a slot.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      seg_r    <= {7{INVERT}};
      dp_out_r <= INVERT;
      an_r     <= {DIGITS{AN_INVERT}};
    end else begin
      seg_r    <= pattern_s ^ {7{INVERT}};
      dp_out_r <= digit_dp_s ^ INVERT;
      if (pcnt_r == {PW{1'b0}}) begin
        an_r <= {DIGITS{AN_INVERT}};
      end else begin
        an_r <= onehot_s ^ {DIGITS{AN_INVERT}};
      end
    end
  end

  assign seg    = seg_r;
  assign dp_out = dp_out_r;
  assign an     = an_r;
  assign frame  = frame_r;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Bench for seg7_scan_driver: a 4-digit active-low instance and a 1-digit
// active-high instance share clock and reset. A time-based reference model
// predicts every output each cycle; literal checks pin key values.

module tb_seg7_scan_driver;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst = 1'b0;

  // 4-digit instance, PRESCALE 4, active-low segments and anodes
  logic        load, blank_lz;
  logic [15:0] value;
  logic [3:0]  dp;
  logic [6:0]  seg;
  logic        dp_out, frame;
  logic [3:0]  an;

  // 1-digit instance, PRESCALE 2, active-high everything
  logic        load2, blank2;
  logic [3:0]  value2;
  logic [0:0]  dp2;
  logic [6:0]  seg2;
  logic        dp_out2, frame2;
  logic [0:0]  an2;

  seg7_scan_driver #(.DIGITS(4), .PRESCALE(4), .INVERT(1'b1), .AN_INVERT(1'b1)) dut4 (
    .clk(clk), .rst(rst), .load(load), .value(value), .dp(dp), .blank_lz(blank_lz),
    .seg(seg), .dp_out(dp_out), .an(an), .frame(frame));

  seg7_scan_driver #(.DIGITS(1), .PRESCALE(2), .INVERT(1'b0), .AN_INVERT(1'b0)) dut1 (
    .clk(clk), .rst(rst), .load(load2), .value(value2), .dp(dp2), .blank_lz(blank2),
    .seg(seg2), .dp_out(dp_out2), .an(an2), .frame(frame2));

  int checks = 0;
  int errors = 0;

  bit [6:0] tbl [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                         7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s got %0h want %0h at %0t", name, act, want, $time);
    end
  endtask

  // Outputs registered at the edge that ends cycle s (s cycles since release):
  // slot position and digit follow from s, the digit content from the display.
  function automatic logic [15:0] exp_out(input int d, input int p, input bit inv,
      input bit aninv, input logic [31:0] val, input logic [7:0] dpv, input bit blz,
      input int s);
    int pc, id;
    logic [31:0] upper;
    logic [6:0]  pat;
    logic        dpo;
    logic [7:0]  a;
    logic [8:0]  mask;
    pc = s % p;
    id = (s / p) % d;
    upper = val >> (4 * id);
    pat = tbl[upper[3:0]];
    if (blz && id > 0 && upper == 32'h0) pat = 7'h00;
    if (inv) pat = ~pat;
    dpo = dpv[id] ^ inv;
    a = (pc == 0) ? 8'h00 : (8'h01 << id);
    mask = (9'h001 << d) - 9'h001;
    if (aninv) a = a ^ mask[7:0];
    return {pat, dpo, a};
  endfunction

  // Reference model, 4-digit instance: display = latest load at or before the
  // most recent boundary; boundaries fall every 16 cycles after release.
  int          s1;
  logic [15:0] shv1, dv1;
  logic [3:0]  shd1, dd1;
  logic [15:0] e1 = {7'h7F, 1'b1, 8'h0F};
  logic        f1 = 1'b0;
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      s1 <= 0; shv1 <= 16'h0; shd1 <= 4'h0; dv1 <= 16'h0; dd1 <= 4'h0;
      e1 <= {7'h7F, 1'b1, 8'h0F}; f1 <= 1'b0;
    end else begin
      e1 <= exp_out(4, 4, 1'b1, 1'b1, {16'h0, dv1}, {4'h0, dd1}, blank_lz, s1);
      if (load) begin shv1 <= value; shd1 <= dp; end
      if ((s1 + 1) % 16 == 0) begin
        dv1 <= load ? value : shv1;
        dd1 <= load ? dp : shd1;
      end
      f1 <= ((s1 + 1) % 16 == 0);
      s1 <= s1 + 1;
    end
  end

  // Reference model, 1-digit instance: every second cycle is a boundary.
  int          s2;
  logic [3:0]  shv2, dv2;
  logic        shd2, dd2;
  logic [15:0] e2 = 16'h0;
  logic        f2 = 1'b0;
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      s2 <= 0; shv2 <= 4'h0; shd2 <= 1'b0; dv2 <= 4'h0; dd2 <= 1'b0;
      e2 <= 16'h0; f2 <= 1'b0;
    end else begin
      e2 <= exp_out(1, 2, 1'b0, 1'b0, {28'h0, dv2}, {7'h0, dd2}, blank2, s2);
      if (load2) begin shv2 <= value2; shd2 <= dp2[0]; end
      if ((s2 + 1) % 2 == 0) begin
        dv2 <= load2 ? value2 : shv2;
        dd2 <= load2 ? dp2[0] : shd2;
      end
      f2 <= ((s2 + 1) % 2 == 0);
      s2 <= s2 + 1;
    end
  end

  // Per-cycle comparison of both instances against the model.
  always @(negedge clk) begin
    chk("scan4", {19'h0, seg, dp_out, an, frame}, {19'h0, e1[15:8], e1[3:0], f1});
    chk("scan1", {22'h0, seg2, dp_out2, an2, frame2}, {22'h0, e2[15:8], e2[0], f2});
  end

  // Wait (bounded) until the 4-digit anodes equal target, then check seg/dp.
  task automatic lit(input logic [3:0] target, input string name,
                     input logic [6:0] want_seg, input bit chk_dp, input logic want_dp);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 24 && !ok; i++) begin
      @(negedge clk);
      if (an == target) ok = 1'b1;
    end
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL %s_timeout an %0h never reached %0h", name, an, target);
    end else begin
      chk(name, {25'h0, seg}, {25'h0, want_seg});
      if (chk_dp) chk({name, "_dp"}, {31'h0, dp_out}, {31'h0, want_dp});
    end
  endtask

  // One-cycle load, then let at least one frame boundary pass.
  task automatic do_load(input logic [15:0] v, input logic [3:0] d);
    @(negedge clk);
    value = v; dp = d; load = 1'b1;
    @(negedge clk);
    load = 1'b0; value = 16'($urandom); dp = 4'($urandom);
    repeat (32) @(negedge clk);
  endtask

  logic [3:0] an_seq [16] = '{4'hF, 4'hE, 4'hE, 4'hE, 4'hF, 4'hD, 4'hD, 4'hD,
                              4'hF, 4'hB, 4'hB, 4'hB, 4'hF, 4'h7, 4'h7, 4'h7};
  logic [15:0] mask_tbl [5] = '{16'hFFFF, 16'h0FFF, 16'h00FF, 16'h000F, 16'h0000};

  initial begin
    load = 1'b0; value = 16'h0; dp = 4'h0; blank_lz = 1'b0;
    load2 = 1'b1; value2 = 4'h8; dp2 = 1'b0; blank2 = 1'b0;
    #1 rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_seg", {25'h0, seg}, 32'h7F);
    chk("rst_dp", {31'h0, dp_out}, 32'h1);
    chk("rst_an", {28'h0, an}, 32'hF);
    chk("rst_seg1", {25'h0, seg2}, 32'h00);
    rst = 1'b0;
    repeat (10) @(negedge clk);
    // Reset mid-scan, between clock edges.
    #2 rst = 1'b1;
    #1;
    chk("midrst_seg", {25'h0, seg}, 32'h7F);
    chk("midrst_dp", {31'h0, dp_out}, 32'h1);
    chk("midrst_an", {28'h0, an}, 32'hF);
    chk("midrst_an1", {31'h0, an2}, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 16; k++) begin
      @(negedge clk);
      chk("an_seq", {28'h0, an}, {28'h0, an_seq[k]});
      if (k < 4) chk("an1_seq", {31'h0, an2}, (k % 2 == 0) ? 32'h0 : 32'h1);
      if (k == 3) chk("seg1_8", {25'h0, seg2}, 32'h7F);
    end

    // Decode sweep.
    do_load(16'h0123, 4'h0); lit(4'hE, "dec_0123_d0", 7'h30, 1'b1, 1'b1);
    do_load(16'h4567, 4'h0); lit(4'hE, "dec_4567_d0", 7'h78, 1'b0, 1'b0);
    do_load(16'h89AB, 4'h0); lit(4'hE, "dec_89AB_d0", 7'h03, 1'b0, 1'b0);
    do_load(16'hCDEF, 4'h0); lit(4'h7, "dec_CDEF_d3", 7'h46, 1'b0, 1'b0);

    // Leading-zero blanking.
    blank_lz = 1'b1;
    do_load(16'h0050, 4'b1000);
    lit(4'h7, "lz_d3", 7'h7F, 1'b1, 1'b0);
    lit(4'hB, "lz_d2", 7'h7F, 1'b1, 1'b1);
    lit(4'hD, "lz_d1", 7'h12, 1'b0, 1'b0);
    lit(4'hE, "lz_d0", 7'h40, 1'b0, 1'b0);
    do_load(16'h0000, 4'h0);
    lit(4'h7, "zero_d3", 7'h7F, 1'b0, 1'b0);
    lit(4'hE, "zero_d0", 7'h40, 1'b0, 1'b0);
    blank_lz = 1'b0;

    // Tear-free update: second load lands during digit 1's slot.
    do_load(16'h1111, 4'h0);
    lit(4'hD, "tear_d1", 7'h79, 1'b0, 1'b0);
    value = 16'h2222; load = 1'b1;
    @(negedge clk);
    load = 1'b0; value = 16'h0;
    lit(4'h7, "tear_old_d3", 7'h79, 1'b0, 1'b0);
    lit(4'hE, "tear_new_d0", 7'h24, 1'b0, 1'b0);

    // Load exactly on the frame-boundary cycle.
    for (int i = 0; i < 20 && (s1 % 16) != 15; i++) @(negedge clk);
    chk("boundary_align", s1 % 16, 32'd15);
    value = 16'h3333; load = 1'b1;
    @(negedge clk);
    load = 1'b0; value = 16'h0;
    lit(4'h7, "simul_d3", 7'h30, 1'b0, 1'b0);

    // Randomised traffic, including one asynchronous reset mid-run.
    for (int i = 0; i < 600; i++) begin
      @(negedge clk);
      load  = ($urandom_range(0, 7) == 0);
      value = 16'($urandom) & mask_tbl[$urandom_range(0, 4)];
      dp    = 4'($urandom);
      if ($urandom_range(0, 19) == 0) blank_lz = ~blank_lz;
      load2  = ($urandom_range(0, 3) == 0);
      value2 = 4'($urandom);
      dp2    = 1'($urandom);
      blank2 = 1'($urandom);
      if (i == 300) begin
        #2 rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
      end
    end

    @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/seg7_scan_driver.md
# seg7_scan_driver

Time-multiplexed seven-segment display driver for common-anode/common-cathode multi-digit displays. It is the parametrised, clocked successor of the single-digit hex-to-segment decoder. It latches a packed hex value and decimal points, scans the digits at a programmable rate and decodes the full hex set 0–F. It also provides tear-free frame updates, optional leading-zero blanking and a one-cycle anti-ghosting dead time between digit slots. It sits between user logic (counters, debug registers) and the board-level segment/anode pins.

## Interface
- DIGITS, 4: number of digits scanned; legal 1..8.
- PRESCALE, 50000: clock cycles per digit slot; legal ≥ 2.
- INVERT, 1: 1 = segment and dp outputs active-low; 0 = active-high.
- AN_INVERT, 1: 1 = anode outputs active-low; 0 = active-high.

Ports:
- clk  in  1  single system clock; all state on rising edge.
- rst  in  1  asynchronous, active-high reset.
- load  in  1  capture `value`/`dp` into shadow register this cycle.
- value  in  4*DIGITS  packed nibbles; nibble i = `value[4i+3:4i]` = digit i, digit 0 rightmost.
- dp  in  DIGITS  decimal point per digit, 1 = lit.
- blank_lz  in  1  1 = blank leading zeros.
- seg  out  7  segments, `seg[0]`=a … `seg[6]`=g, polarity per INVERT.
- dp_out  out  1  decimal point of the currently driven digit, polarity per INVERT.
- an  out  DIGITS  digit enables, one-hot when active, polarity per AN_INVERT.
- frame  out  1  one-cycle pulse at each frame boundary.

## Operation
- Prescaler `pcnt` counts 0..PRESCALE-1 and wraps. A tick occurs when `pcnt == PRESCALE-1`.
- On a tick, digit index `idx` increments 0..DIGITS-1 and wraps to 0.
- **Shadow register.** `shadow <= {value, dp}` on any cycle with `load`=1. Otherwise it holds.
- **Display register.**
  - A frame boundary is a tick with `idx == DIGITS-1`.
  - At a frame boundary, `disp <= load ? {value, dp} : shadow`. A load on the boundary cycle therefore reaches `disp` immediately.
  - `disp` changes only at frame boundaries, so no frame ever mixes old and new digits.
- **frame.** Registered; equals 1 for exactly the cycle after each frame boundary edge.
- **Decode.** Active-high gfedcba patterns, hex 0..F: 3F,06,5B,4F,66,6D,7D,07,7F,6F,77,7C,39,5E,79,71. Pin value = pattern XOR `{7{INVERT}}`.
- **Leading-zero blanking.**
  - When `blank_lz`=1, digit i>0 is blanked if its nibble and all higher nibbles in `disp` are 0.
  - Digit 0 is never blanked.
  - A blanked digit has pattern 0000000 but still shows its dp.
  - `blank_lz` is sampled live, not shadowed.
- **Registered outputs.** `seg`, `dp_out` and `an` are registered from the current `pcnt`, `idx` and `disp`:
  - When `pcnt == 0` (dead-time cycle), all anodes are inactive.
  - Otherwise `an` is one-hot at `idx`.
  - Pin value = onehot XOR `{DIGITS{AN_INVERT}}`.
  - `seg` and `dp_out` always reflect digit `idx`, including during dead time.
- **DIGITS=1.** `idx` stays 0, and every tick is a frame boundary.

## Timing
- **Reset values.** All of the following are asynchronous on `rst`:
  - `pcnt`=0, `idx`=0, `shadow`=0, `disp`=0, `frame`=0.
  - `seg` = `{7{INVERT}}` (all off), `dp_out` = INVERT (off), `an` = `{DIGITS{AN_INVERT}}` (all off).
- **Reset mid-operation.** Outputs go to the reset values immediately, without waiting for a clock. Scanning restarts from digit 0 at `pcnt` 0 on the first edge after release.
- **Output latency.** Output registers lag `pcnt`/`idx` by one cycle. After release, edge 1 registers the state `pcnt`=0 (dead time), so `an` stays all-off. Digit 0 becomes active from edge 2.
- **Slot timing.** Each slot lasts PRESCALE cycles: 1 dead cycle plus PRESCALE-1 cycles with the anode active.
- **Frame timing.** Frame period is DIGITS*PRESCALE cycles. The first frame pulse appears DIGITS*PRESCALE cycles after release.
- **Load-to-display latency.** A load becomes visible at the next frame boundary, at most DIGITS*PRESCALE cycles later. It is shown on `seg` starting from the digit-0 slot that follows.
- **Multiple loads.** When several loads occur within one frame, the last one before or on the boundary wins.

## Test plan
- **Reset.** DIGITS=4, PRESCALE=4, INVERT=1, AN_INVERT=1; assert `rst` mid-scan with no clock edge. Required: `seg`=7'h7F, `dp_out`=1, `an`=4'hF immediately. After release, `an` cycles E,D,B,7 (active-low), each for 3 cycles with an F dead cycle between them.
- **Decode sweep.** Load 16'h0123, then 16'h4567, 16'h89AB and 16'hCDEF, one per frame. Required: for each digit the active-low `seg` equals the inverted table value, e.g. digit 0 of 16'h0123 shows ~7'h4F = 7'h30.
- **Leading-zero blanking.**
  - `blank_lz`=1, value 16'h0050, dp=4'b1000: digits 3 and 2 show `seg`=7'h7F. Digit 3 has `dp_out`=0. Digit 1 shows 5 (7'h12) and digit 0 shows 0 (7'h40).
  - value 16'h0000: only digit 0 is lit.
- **Tear-free update.** Load 16'h1111, then load 16'h2222 during the slot of digit 1. Required: the current frame shows all "1". The next frame shows all "2". `frame` pulses once per 16 cycles.
- **Simultaneous load and boundary.** Pulse `load` with 16'h3333 exactly on the frame-boundary cycle. Required: the following frame shows "3333" with no extra frame of latency.
- **DIGITS=1 and polarity.** DIGITS=1, PRESCALE=2, INVERT=0, AN_INVERT=0, value 4'h8. Required: `an` alternates 0,1. `seg`=7'h7F. `frame` pulses every 2 cycles.
